// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared widths, opcodes and state encoding for the ROM sequencer
package seq_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int OP_W   = 3;
  localparam int ARG_W  = DATA_W - OP_W;

  localparam logic [OP_W-1:0] OP_JMP  = 3'b101;
  localparam logic [OP_W-1:0] OP_JZ   = 3'b110;
  localparam logic [OP_W-1:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;

  // Opcodes 000-100 belong to the datapath; the rest are control flow.
  function automatic logic is_datapath_op(input logic [OP_W-1:0] op);
    return op <= 3'b100;
  endfunction

endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - 5-bit program counter with clear, load and wrapping increment
module program_counter
  import seq_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              increment,
  output logic [ADDR_W-1:0] value
);

  // Increment relies on natural 5-bit overflow so 31 wraps to 0.
  always_ff @(posedge clock) begin
    if (reset)          value <= '0;
    else if (clear)     value <= '0;
    else if (load)      value <= load_value;
    else if (increment) value <= value + ADDR_W'(1);
  end

endmodule

// File: rtl/rom_sequencer.sv
// rtl/rom_sequencer.sv - fetch/decode/issue controller for the 32x8 program ROM
module rom_sequencer
  import seq_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              exec_valid,
  output logic [OP_W-1:0]   exec_op,
  output logic [ARG_W-1:0]  exec_arg,
  input  logic              exec_ready,
  input  logic              zero_flag,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [7:0]        instr_count
);

  state_t            state, state_next;
  logic [DATA_W-1:0] ir;
  logic              pc_clear, pc_load, pc_inc;
  logic              ir_load, retire, count_clear;
  logic              exec_set, exec_clear;
  logic [OP_W-1:0]   ir_op;

  assign ir_op = ir[DATA_W-1:ARG_W];

  program_counter u_pc (
    .clock      (clock),
    .reset      (reset),
    .clear      (pc_clear),
    .load       (pc_load),
    .load_value (ir[ADDR_W-1:0]),
    .increment  (pc_inc),
    .value      (pc)
  );

  assign rom_addr = pc;
  assign busy     = (state == FETCH) || (state == DECODE) || (state == EXEC);
  assign halted   = (state == HALT);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    pc_clear    = 1'b0;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    ir_load     = 1'b0;
    retire      = 1'b0;
    count_clear = 1'b0;
    exec_set    = 1'b0;
    exec_clear  = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          state_next  = FETCH;
          pc_clear    = 1'b1;
          count_clear = 1'b1;
        end
      end
      FETCH: begin
        ir_load    = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        if (is_datapath_op(ir_op)) begin
          exec_set   = 1'b1;
          state_next = EXEC;
        end else if (ir_op == OP_HALT) begin
          retire     = 1'b1;
          state_next = HALT;
        end else begin
          // zero_flag matters only here, for a JZ being decoded.
          retire     = 1'b1;
          state_next = FETCH;
          if (ir_op == OP_JMP || zero_flag) pc_load = 1'b1;
          else                              pc_inc  = 1'b1;
        end
      end
      EXEC: begin
        if (exec_ready) begin
          pc_inc     = 1'b1;
          retire     = 1'b1;
          exec_clear = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)        ir <= '0;
    else if (ir_load) ir <= rom_data;
  end

  // Offer registers are loaded while leaving DECODE so exec_op/exec_arg stay frozen across stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      exec_valid <= 1'b0;
      exec_op    <= '0;
      exec_arg   <= '0;
    end else if (exec_set) begin
      exec_valid <= 1'b1;
      exec_op    <= ir_op;
      exec_arg   <= ir[ARG_W-1:0];
    end else if (exec_clear) begin
      exec_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                               instr_count <= '0;
    else if (count_clear)                    instr_count <= '0;
    else if (retire && instr_count != 8'hFF) instr_count <= instr_count + 8'd1;
  end

endmodule

// File: tb/tb_rom_sequencer.sv
// tb/tb_rom_sequencer.sv - scoreboard bench for rom_sequencer against an instruction-level program model
module tb_rom_sequencer;
  import seq_pkg::*;

  logic       clock = 1'b0;
  logic       reset, start, exec_ready, zero_flag;
  logic [4:0] rom_addr, pc, exec_arg;
  logic [7:0] rom_data, instr_count;
  logic       exec_valid, busy, halted;
  logic [2:0] exec_op;

  logic [7:0] rom [32];
  bit         zf_tab [32];

  typedef struct {
    logic [2:0] op;
    logic [4:0] arg;
    logic [4:0] addr;
  } xfer_t;
  xfer_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int ready_mode = 2;

  rom_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .exec_valid  (exec_valid),
    .exec_op     (exec_op),
    .exec_arg    (exec_arg),
    .exec_ready  (exec_ready),
    .zero_flag   (zero_flag),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .instr_count (instr_count)
  );

  always #5 clock = ~clock;

  assign rom_data  = rom[rom_addr];
  assign zero_flag = zf_tab[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (ready_mode == 0)      exec_ready = ($urandom_range(0, 3) != 0);
    else if (ready_mode == 1) exec_ready = 1'b1;
  end

  logic       pv = 1'b0, pr = 1'b0, prst = 1'b1;
  logic [2:0] pop;
  logic [4:0] parg, ppc;

  always @(negedge clock) begin : monitor
    xfer_t e;
    if (!prst && pv && !pr) begin
      check("hold_valid", 32'(exec_valid), 32'd1);
      check("hold_op", 32'(exec_op), 32'(pop));
      check("hold_arg", 32'(exec_arg), 32'(parg));
      check("hold_pc", 32'(pc), 32'(ppc));
    end
    if (!reset && exec_valid && exec_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_transfer: actual op %0d arg %0d required none", exec_op, exec_arg);
      end else begin
        e = exp_q.pop_front();
        check("xfer_op", 32'(exec_op), 32'(e.op));
        check("xfer_arg", 32'(exec_arg), 32'(e.arg));
        check("xfer_pc", 32'(pc), 32'(e.addr));
      end
    end
    pv = exec_valid; pr = exec_ready; prst = reset;
    pop = exec_op; parg = exec_arg; ppc = pc;
  end

  // Walks the program as an instruction-set interpreter, recording every datapath issue.
  task automatic model_run(input int max_ret, output int cnt, output logic [4:0] fpc, output bit fhalt);
    int retired = 0;
    logic [4:0] p = 5'd0;
    logic [7:0] ins;
    xfer_t x;
    fhalt = 1'b0;
    while (retired < max_ret && !fhalt) begin
      ins = rom[p];
      if (ins[7:5] <= 3'd4) begin
        x.op = ins[7:5]; x.arg = ins[4:0]; x.addr = p;
        exp_q.push_back(x);
        p = p + 5'd1;
      end else if (ins[7:5] == 3'd5) p = ins[4:0];
      else if (ins[7:5] == 3'd6)     p = zf_tab[p] ? ins[4:0] : p + 5'd1;
      else                           fhalt = 1'b1;
      retired++;
    end
    cnt = (retired > 255) ? 255 : retired;
    fpc = p;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 32; i++) begin rom[i] = v; zf_tab[i] = 1'b0; end
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic do_reset(input string tag, input bit with_start);
    @(posedge clock); #1 reset = 1'b1; start = with_start;
    @(posedge clock); #1 reset = 1'b0; start = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check({tag, "_rst_valid"}, 32'(exec_valid), 32'd0);
    check({tag, "_rst_op"}, 32'(exec_op), 32'd0);
    check({tag, "_rst_arg"}, 32'(exec_arg), 32'd0);
    check({tag, "_rst_pc"}, 32'(pc), 32'd0);
    check({tag, "_rst_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_rst_busy"}, 32'(busy), 32'd0);
    check({tag, "_rst_halted"}, 32'(halted), 32'd0);
    check({tag, "_rst_count"}, 32'(instr_count), 32'd0);
    @(negedge clock);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_pc"}, 32'(pc), 32'd0);
  endtask

  task automatic run_program(input string tag, input int max_ret, input int budget);
    int cnt, cyc;
    logic [4:0] fpc;
    bit fh;
    model_run(max_ret, cnt, fpc, fh);
    pulse_start();
    @(negedge clock);
    check({tag, "_start_pc"}, 32'(pc), 32'd0);
    check({tag, "_start_count"}, 32'(instr_count), 32'd0);
    check({tag, "_start_busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!(32'(instr_count) == cnt && (!fh || halted)) && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
    check({tag, "_in_budget"}, 32'(cyc < budget), 32'd1);
    check({tag, "_pc"}, 32'(pc), 32'(fpc));
    check({tag, "_count"}, 32'(instr_count), 32'(cnt));
    check({tag, "_halted"}, 32'(halted), 32'(fh));
    check({tag, "_busy"}, 32'(busy), 32'(!fh));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cnt, cyc;
    logic [4:0] fpc;
    bit fh;
    reset = 1'b1; start = 1'b0; exec_ready = 1'b0;
    fill(8'h00);
    repeat (3) @(posedge clock);
    do_reset("init", 1'b0);

    // Four stalled EXEC cycles, then a single transfer.
    ready_mode = 2; exec_ready = 1'b0;
    fill(8'hE0); rom[0] = 8'b001_100_00;
    model_run(10, cnt, fpc, fh);
    pulse_start();
    cyc = 1;
    @(negedge clock);
    while (!exec_valid && cyc < 10) begin @(negedge clock); cyc++; end
    check("exec_latency", 32'(cyc), 32'd3);
    check("first_op", 32'(exec_op), 32'd1);
    check("first_arg", 32'(exec_arg), 32'd16);
    repeat (3) @(negedge clock);
    check("stall_pc", 32'(pc), 32'd0);
    @(posedge clock); #1 exec_ready = 1'b1;
    @(posedge clock); #1 exec_ready = 1'b0;
    @(negedge clock);
    check("valid_drop", 32'(exec_valid), 32'd0);
    check("pc_after_xfer", 32'(pc), 32'd1);
    check("count_after_xfer", 32'(instr_count), 32'd1);
    cyc = 0;
    while (!halted && cyc < 20) begin @(negedge clock); cyc++; end
    check("hold_halted", 32'(halted), 32'd1);
    check("hold_count", 32'(instr_count), 32'(cnt));
    check("hold_final_pc", 32'(pc), 32'(fpc));
    check("hold_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    ready_mode = 0;
    fill(8'hE0); rom[0] = 8'b101_01001; rom[9] = 8'b101_01011; rom[11] = 8'b011_00011;
    run_program("jmp", 50, 500);

    fill(8'hE0); rom[0] = 8'b010_00001; rom[1] = 8'b100_00010; rom[2] = 8'b110_00111;
    zf_tab[2] = 1'b1;
    run_program("jz_taken", 50, 500);
    zf_tab[2] = 1'b0;
    run_program("jz_fall", 50, 500);

    fill(8'hE0); rom[0] = 8'b101_11110; rom[30] = 8'b000_00101; rom[31] = 8'b100_11111;
    run_program("wrap", 7, 500);
    do_reset("wrap", 1'b0);

    fill(8'hE0);
    for (int i = 0; i < 5; i++) rom[i] = 8'($urandom_range(0, 159));
    run_program("halt5", 50, 500);
    run_program("restart", 50, 500);

    // Reset while an instruction is being offered.
    ready_mode = 2; exec_ready = 1'b0;
    fill(8'h20);
    pulse_start();
    cyc = 0;
    while (!exec_valid && cyc < 10) begin @(negedge clock); cyc++; end
    check("mid_exec_reached", 32'(exec_valid), 32'd1);
    do_reset("mid_exec", 1'b0);
    do_reset("with_start", 1'b1);

    ready_mode = 1;
    fill(8'hE0); rom[0] = 8'b101_00000;
    run_program("saturate", 300, 800);
    repeat (20) @(negedge clock);
    check("saturate_hold", 32'(instr_count), 32'd255);
    do_reset("saturate", 1'b0);

    ready_mode = 0;
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 32; i++) begin
        rom[i] = 8'($urandom);
        zf_tab[i] = 1'($urandom);
      end
      run_program($sformatf("rand%0d", r), 40, 3000);
      if (!halted) do_reset($sformatf("rand%0d", r), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rom_sequencer.md
# rom_sequencer

Fetch/decode/issue controller for the 32×8 program ROM. It holds the program counter and drives the ROM address. It captures each 8-bit instruction and handles the control-flow opcodes itself. All other opcodes are issued to the datapath over a valid/ready handshake. It sits between the combinational program ROM and the datapath/ALU, and is the only block that addresses the ROM.

## Interface
- ADDR_W, 5, ROM address / PC width (32 words)
- DATA_W, 8, instruction width
- OP_W, 3, opcode field width (instr[7:5]); argument field is instr[4:0]

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to begin execution at address 0
- rom_addr  out  ADDR_W  ROM address, equals pc
- rom_data  in  DATA_W  ROM output (combinational, valid same cycle as rom_addr)
- exec_valid  out  1  datapath instruction offered
- exec_op  out  OP_W  opcode of offered instruction
- exec_arg  out  5  instr[4:0] of offered instruction
- exec_ready  in  1  datapath accepts the instruction this cycle
- zero_flag  in  1  datapath zero flag, used by JZ
- pc  out  ADDR_W  current program counter
- busy  out  1  high in FETCH/DECODE/EXEC
- halted  out  1  high in HALT state
- instr_count  out  8  count of retired instructions, saturating at 255

## Operation
- Opcodes, from instr[7:5]:
  - 000–100: datapath instructions, issued via the handshake.
  - 101 JMP: pc ← instr[4:0].
  - 110 JZ: if zero_flag, pc ← instr[4:0]; else pc+1.
  - 111 HALT.
- States and transitions:
  - IDLE: on start → FETCH, pc ← 0, instr_count ← 0.
  - FETCH: ir ← rom_data; → DECODE.
  - DECODE, on opcode 000–100: → EXEC.
  - DECODE, on JMP/JZ: update pc, retire, → FETCH.
  - DECODE, on HALT: retire, → HALT; pc unchanged.
  - EXEC: exec_valid=1, exec_op=ir[7:5], exec_arg=ir[4:0]. On exec_ready: pc ← pc+1, retire, → FETCH.
  - HALT: on start → FETCH, pc ← 0, instr_count ← 0.
- PC increments modulo 32: 31 → 0, no error. JMP/JZ to its own address is a legal infinite loop.
- zero_flag is sampled only in the DECODE cycle of a JZ.
- start is ignored in FETCH/DECODE/EXEC.
- Retire means instr_count ← instr_count+1 unless it is already 255.
- Reset values:
  - state IDLE; pc 0; rom_addr 0; ir 0.
  - exec_valid 0; exec_op 0; exec_arg 0.
  - busy 0; halted 0; instr_count 0.

## Timing
- rom_addr = pc, combinational from the pc register.
- ir is registered at the end of the FETCH cycle.
- Latency:
  - Datapath instruction: 3 cycles minimum (FETCH, DECODE, EXEC with exec_ready=1).
  - Each EXEC cycle with exec_ready=0 adds 1 cycle.
  - JMP/JZ/HALT: 2 cycles.
- Handshake:
  - exec_valid rises on the cycle after DECODE.
  - exec_valid is held, with exec_op/exec_arg stable, until the cycle with exec_ready=1.
  - exec_valid drops on the following cycle.
  - Transfer occurs on a cycle where exec_valid & exec_ready are both 1.
  - exec_ready while exec_valid=0 is ignored.
  - exec_ready may be tied high.
- Simultaneous start and reset: reset wins.
- Reset mid-EXEC: exec_valid is 0 after the reset edge and no retire occurs.
- All outputs are registered, except rom_addr, busy and halted, which are decoded from registers.

## Structure
- The shared package/include `seq_pkg` holds:
  - opcode constants OP_JMP=3'b101, OP_JZ=3'b110, OP_HALT=3'b111;
  - state encoding IDLE/FETCH/DECODE/EXEC/HALT;
  - ADDR_W/DATA_W defaults.
- One sub-module is natural: `program_counter`, with load/increment/clear, a 5-bit wrap and the current value output.
- The FSM, instruction register and instruction counter stay in `rom_sequencer`.
- The ROM stays an external instance.

## Test plan
- Reset then start. ROM[0]=8'b001_100_00, exec_ready=1 → exec_valid in cycle 3, exec_op=3'b001, exec_arg=5'b10000, pc=1 after transfer.
- ROM[9]=8'b101_01011 (JMP 11), reached from pc=9 → no exec_valid, pc=11 two cycles after fetch, instr_count +1.
- JZ: ROM[2]=8'b110_00111.
  - With zero_flag=1 → pc=7.
  - Repeat with zero_flag=0 → pc=3.
- exec_ready held 0 for 4 cycles during EXEC:
  - exec_valid, exec_op and exec_arg stay constant for all 4 cycles;
  - pc does not change;
  - exactly one transfer occurs when exec_ready=1.
- ROM[31] a datapath op → pc wraps to 0. HALT at ROM[5] → halted=1, busy=0, pc=5, start restarts at pc=0 with instr_count=0.
- Reset asserted mid-EXEC, and reset together with start → all outputs at reset values next cycle, state IDLE.
